// File: rtl/adc_frame_aligner.sv
// Per-lane frame-word aligner for a deserialised ADC link: issues bitslips until
// each lane's frame word matches the training pattern, then tracks lock.
module adc_frame_aligner #(
  parameter int unsigned AdcBits      = 14,
  parameter int unsigned NumLanes     = 1,
  parameter logic [15:0] FrmPattern   = 16'b0011111110000000,
  parameter int unsigned SettleCycles = 32,
  parameter int unsigned LockCount    = 4,
  parameter int unsigned UnlockCount  = 4,
  parameter int unsigned MaxSlips     = 2 * AdcBits
) (
  input  logic                         FrmClkDiv,
  input  logic                         FrmRst,
  input  logic                         BitClkDone,
  input  logic                         ReAlign,
  input  logic [NumLanes*AdcBits-1:0]  FrmWord,
  output logic [NumLanes-1:0]          FrmBitslip,
  output logic [NumLanes-1:0]          LaneLocked,
  output logic                         FrmAlignDone,
  output logic                         FrmAlignErr,
  output logic [NumLanes*8-1:0]        SlipCount
);

  typedef enum logic [2:0] {
    ST_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_LOCKED,
    ST_FAIL
  } lane_state_e;

  localparam logic [AdcBits-1:0] Pattern      = FrmPattern[AdcBits-1:0];
  localparam logic [7:0]         SettleLast   = 8'(SettleCycles - 1);
  localparam logic [3:0]         LockTarget   = 4'(LockCount);
  localparam logic [3:0]         UnlockTarget = 4'(UnlockCount);
  localparam logic [7:0]         SlipLimit    = 8'(MaxSlips);

  logic                restart;
  logic [NumLanes-1:0] fail_w;
  logic                done_q;
  logic                err_q;

  // Reset, loss of bit-clock alignment and a realign request all land in the same place.
  assign restart = FrmRst | ~BitClkDone | ReAlign;

  for (genvar i = 0; i < NumLanes; i++) begin : g_lane
    lane_state_e        state_q;
    logic [7:0]         settle_q;
    logic [7:0]         slip_q;
    logic [3:0]         match_q;
    logic [3:0]         miss_q;
    logic [AdcBits-1:0] word;
    logic               hit;

    assign word = FrmWord[i*AdcBits +: AdcBits];
    assign hit  = (word == Pattern);

    // NOTE: reset is synchronous (sampled on the clock edge) and all state uses
    // non-blocking assignments so every lane sees the same pre-edge values.
    always_ff @(posedge FrmClkDiv) begin
      if (restart) begin
        state_q  <= ST_SETTLE;
        settle_q <= '0;
        slip_q   <= '0;
        match_q  <= '0;
        miss_q   <= '0;
      end else begin
        case (state_q)
          ST_SETTLE: begin
            if (settle_q == SettleLast) begin
              state_q  <= ST_CHECK;
              settle_q <= '0;
            end else begin
              settle_q <= settle_q + 8'd1;
            end
          end
          ST_CHECK: begin
            if (hit) begin
              match_q <= match_q + 4'd1;
              if (match_q + 4'd1 == LockTarget) begin
                state_q <= ST_LOCKED;
                miss_q  <= '0;
              end
            end else begin
              match_q <= '0;
              state_q <= (slip_q == SlipLimit) ? ST_FAIL : ST_SLIP;
            end
          end
          ST_SLIP: begin
            slip_q   <= (slip_q == 8'hFF) ? slip_q : slip_q + 8'd1;
            settle_q <= '0;
            state_q  <= ST_SETTLE;
          end
          ST_LOCKED: begin
            if (hit) begin
              miss_q <= '0;
            end else if (miss_q + 4'd1 == UnlockTarget) begin
              // Lost lock: restart this lane's search from scratch.
              state_q  <= ST_SETTLE;
              settle_q <= '0;
              slip_q   <= '0;
              match_q  <= '0;
              miss_q   <= '0;
            end else begin
              miss_q <= miss_q + 4'd1;
            end
          end
          ST_FAIL: state_q <= ST_FAIL;
          default: state_q <= ST_SETTLE;
        endcase
      end
    end

    assign FrmBitslip[i]       = (state_q == ST_SLIP);
    assign LaneLocked[i]       = (state_q == ST_LOCKED);
    assign fail_w[i]           = (state_q == ST_FAIL);
    assign SlipCount[i*8 +: 8] = slip_q;
  end

  always_ff @(posedge FrmClkDiv) begin
    if (restart) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= &LaneLocked;
      err_q  <= |fail_w;
    end
  end

  assign FrmAlignDone = done_q;
  assign FrmAlignErr  = err_q;

endmodule

// File: tb/tb_adc_frame_aligner.sv
// Self-checking bench for adc_frame_aligner: a rotating-word deserialiser model drives
// two lanes, and a behavioural lane model predicts every output cycle by cycle.
module tb_adc_frame_aligner;

  localparam int W      = 14;
  localparam int L      = 2;
  localparam int SETTLE = 32;
  localparam int LOCK   = 4;
  localparam int UNLOCK = 4;
  localparam int MAXSL  = 28;
  localparam logic [13:0] PAT = 14'h3F80;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bcd = 1'b1;
  logic          realign = 1'b0;
  logic [L*W-1:0] word = '0;
  logic [L-1:0]  bitslip;
  logic [L-1:0]  locked;
  logic          done;
  logic          err;
  logic [L*8-1:0] slipcnt;

  always #5 clk = ~clk;

  adc_frame_aligner #(
    .AdcBits(W), .NumLanes(L), .FrmPattern(16'b0011111110000000),
    .SettleCycles(SETTLE), .LockCount(LOCK), .UnlockCount(UNLOCK), .MaxSlips(MAXSL)
  ) dut (
    .FrmClkDiv(clk), .FrmRst(rst), .BitClkDone(bcd), .ReAlign(realign),
    .FrmWord(word), .FrmBitslip(bitslip), .LaneLocked(locked),
    .FrmAlignDone(done), .FrmAlignErr(err), .SlipCount(slipcnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural lane model: cycles left to wait, hit/miss runs, slips so far.
  int m_wait[L], m_hits[L], m_miss[L], m_slips[L];
  bit m_lock[L], m_fail[L], m_pulse[L];
  bit m_done = 1'b0, m_err = 1'b0;

  task automatic model_step();
    bit all_locked = 1'b1;
    bit any_fail = 1'b0;
    bit hit;
    for (int l = 0; l < L; l++) begin
      all_locked &= m_lock[l];
      any_fail   |= m_fail[l];
    end
    if (rst || !bcd || realign) begin
      m_done = 1'b0;
      m_err  = 1'b0;
      for (int l = 0; l < L; l++) begin
        m_wait[l] = SETTLE; m_hits[l] = 0; m_miss[l] = 0; m_slips[l] = 0;
        m_lock[l] = 1'b0; m_fail[l] = 1'b0; m_pulse[l] = 1'b0;
      end
    end else begin
      m_done = all_locked;
      m_err  = any_fail;
      for (int l = 0; l < L; l++) begin
        hit = (word[l*W +: W] == PAT);
        if (m_fail[l]) begin
          // stays failed
        end else if (m_pulse[l]) begin
          m_pulse[l] = 1'b0;
          m_slips[l] = (m_slips[l] >= 255) ? 255 : m_slips[l] + 1;
          m_wait[l]  = SETTLE;
        end else if (m_wait[l] > 0) begin
          m_wait[l]--;
        end else if (m_lock[l]) begin
          m_miss[l] = hit ? 0 : m_miss[l] + 1;
          if (m_miss[l] == UNLOCK) begin
            m_lock[l] = 1'b0; m_wait[l] = SETTLE;
            m_slips[l] = 0; m_hits[l] = 0; m_miss[l] = 0;
          end
        end else if (hit) begin
          m_hits[l]++;
          if (m_hits[l] == LOCK) begin
            m_lock[l] = 1'b1; m_miss[l] = 0;
          end
        end else begin
          m_hits[l] = 0;
          if (m_slips[l] == MAXSL) m_fail[l] = 1'b1;
          else m_pulse[l] = 1'b1;
        end
      end
    end
  endtask

  // Single compare process: model advances on each edge, DUT sampled 1 time unit later.
  initial begin
    logic [L-1:0]   eb, el;
    logic [L*8-1:0] es;
    forever begin
      @(posedge clk);
      model_step();
      #1;
      if (chk_on) begin
        for (int l = 0; l < L; l++) begin
          eb[l] = m_pulse[l];
          el[l] = m_lock[l];
          es[l*8 +: 8] = 8'(m_slips[l]);
        end
        check("bitslip", bitslip, eb);
        check("locked", locked, el);
        check("slipcount", slipcnt, es);
        check("align_done", done, m_done);
        check("align_err", err, m_err);
      end
    end
  end

  // Deserialiser model: each bitslip rotates the presented word one step towards PAT.
  int          offs[L];
  bit          stuck[L];
  int          corrupt_left[L];
  logic [13:0] corrupt_val[L];
  int          step_cnt = 0;
  int          pulse_cnt[L];
  int          p0_times[$];

  function automatic logic [13:0] rotl(input logic [13:0] p, input int k);
    logic [27:0] t;
    t = {p, p};
    return t[27-k -: 14];
  endfunction

  function automatic logic [13:0] bad_word();
    logic [13:0] c;
    do c = 14'($urandom_range(0, 16383)); while (c == PAT);
    return c;
  endfunction

  task automatic apply_words();
    logic [13:0] w;
    for (int l = 0; l < L; l++) begin
      if (stuck[l]) w = '0;
      else if (corrupt_left[l] > 0) begin
        w = corrupt_val[l];
        corrupt_left[l]--;
      end else w = rotl(PAT, offs[l]);
      word[l*W +: W] = w;
    end
  endtask

  task automatic step();
    @(negedge clk);
    step_cnt++;
    for (int l = 0; l < L; l++) begin
      if (bitslip[l] === 1'b1) begin
        offs[l] = (offs[l] + W - 1) % W;
        pulse_cnt[l]++;
        if (l == 0) p0_times.push_back(step_cnt);
      end
    end
    apply_words();
  endtask

  task automatic pulse_realign();
    realign = 1'b1;
    step();
    realign = 1'b0;
    for (int l = 0; l < L; l++) pulse_cnt[l] = 0;
    p0_times.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bitslip"}, bitslip, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_slipcnt"}, slipcnt, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, pulses, lane1_offs;
    for (int l = 0; l < L; l++) begin
      offs[l] = 0; stuck[l] = 0; corrupt_left[l] = 0; pulse_cnt[l] = 0;
    end
    apply_words();

    // Reset, then both lanes already aligned.
    repeat (3) step();
    chk_on = 1'b1;
    check_all_zero("reset");
    rst = 1'b0;
    for (int l = 0; l < L; l++) pulse_cnt[l] = 0;
    repeat (35) step();
    check("s1_locked_c35", locked, 2'b00);
    step();
    check("s1_locked_c36", locked, 2'b11);
    check("s1_done_c36", done, 1'b0);
    step();
    check("s1_done_c37", done, 1'b1);
    repeat (20) step();
    check("s1_slipcnt", slipcnt, 0);
    check("s1_pulses", pulse_cnt[0] + pulse_cnt[1], 0);

    // Lane 0 needs exactly 3 slips.
    offs[0] = 3;
    lane1_offs = $urandom_range(0, W - 1);
    offs[1] = lane1_offs;
    pulse_realign();
    base = step_cnt;
    for (int k = 0; k < 800 && locked !== 2'b11; k++) step();
    check("s2_locked", locked, 2'b11);
    check("s2_pulses0", p0_times.size(), 3);
    if (p0_times.size() == 3) begin
      check("s2_first_pulse", p0_times[0] - base, 33);
      check("s2_gap1", p0_times[1] - p0_times[0], 34);
      check("s2_gap2", p0_times[2] - p0_times[1], 34);
    end
    check("s2_slipcnt0", slipcnt[7:0], 3);
    check("s2_slipcnt1", slipcnt[15:8], lane1_offs);

    // Lane 1 stuck at zero: fails after 28 slips, lane 0 still locks.
    stuck[1] = 1'b1;
    offs[0] = $urandom_range(1, W - 1);
    pulse_realign();
    for (int k = 0; k < 1200 && err !== 1'b1; k++) step();
    repeat (5) step();
    check("s3_err", err, 1'b1);
    check("s3_done", done, 1'b0);
    check("s3_slipcnt1", slipcnt[15:8], 28);
    check("s3_pulses1", pulse_cnt[1], 28);
    check("s3_locked", locked, 2'b01);
    pulse_realign();
    check("s3_err_cleared", err, 1'b0);
    check("s3_slipcnt_cleared", slipcnt, 0);
    stuck[1] = 1'b0;

    // Lock both lanes (lane 0 after 2 slips), then corrupt lane 0.
    offs[0] = 2;
    offs[1] = 0;
    pulse_realign();
    for (int k = 0; k < 300 && locked !== 2'b11; k++) step();
    repeat (2) step();
    check("s4_locked", locked, 2'b11);
    check("s4_done", done, 1'b1);
    check("s4_slipcnt0", slipcnt[7:0], 2);
    corrupt_val[0] = bad_word();
    corrupt_left[0] = 3;
    apply_words();
    repeat (4) step();
    check("s4_corrupt3_locked", locked, 2'b11);
    corrupt_val[0] = bad_word();
    corrupt_left[0] = 4;
    apply_words();
    repeat (3) step();
    check("s4_corrupt4_c3_locked", locked, 2'b11);
    step();
    check("s4_corrupt4_locked", locked, 2'b10);
    check("s4_corrupt4_done_held", done, 1'b1);
    check("s4_corrupt4_slipcnt0", slipcnt[7:0], 0);
    step();
    check("s4_corrupt4_done_drop", done, 1'b0);

    // BitClkDone dropped mid-SETTLE after a slip, then FrmRst during SLIP.
    offs[0] = 5;
    offs[1] = 5;
    pulse_realign();
    repeat (33) step();
    check("s5_first_pulse", bitslip, 2'b11);
    repeat (10) step();
    bcd = 1'b0;
    step();
    check_all_zero("s5_bcd_low");
    bcd = 1'b1;
    pulses = 0;
    for (int k = 0; k < 32; k++) begin
      step();
      if (bitslip !== 2'b00) pulses++;
    end
    check("s5_quiet", pulses, 0);
    step();
    check("s5_pulse_c33", bitslip, 2'b11);
    rst = 1'b1;
    step();
    check_all_zero("s6_rst_in_slip");
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 32; k++) begin
      step();
      if (bitslip !== 2'b00) pulses++;
    end
    check("s6_quiet", pulses, 0);
    step();
    check("s6_pulse_c33", bitslip, 2'b11);

    // Randomised rounds: random offsets, stuck lanes, corruption bursts, restarts.
    for (int r = 0; r < 6; r++) begin
      for (int l = 0; l < L; l++) begin
        offs[l] = $urandom_range(0, W - 1);
        corrupt_left[l] = 0;
      end
      stuck[1] = ($urandom_range(0, 3) == 0);
      pulse_realign();
      for (int k = 0; k < 700; k++) begin
        step();
        for (int l = 0; l < L; l++) begin
          if (corrupt_left[l] == 0 && $urandom_range(0, 79) == 0) begin
            corrupt_val[l] = bad_word();
            corrupt_left[l] = $urandom_range(1, 6);
          end
        end
        realign = ($urandom_range(0, 499) == 0);
        bcd = !($urandom_range(0, 599) == 0);
        rst = ($urandom_range(0, 999) == 0);
      end
      realign = 1'b0;
      bcd = 1'b1;
      rst = 1'b0;
    end
    stuck[1] = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_frame_aligner.md
ADC_FRAME_ALIGNER -- requirements
Module: adc_frame_aligner

Interface
REQ-001 Parameter AdcBits, default 14: deserialised word width per lane; legal values 8, 10, 12, 14, 16.
REQ-002 Parameter NumLanes, default 1: number of independently aligned frame/data lanes; legal range 1..8.
REQ-003 Parameter FrmPattern, default 16'b0011111110000000: expected training word; bits [AdcBits-1:0] are compared.
REQ-004 Parameter SettleCycles, default 32: wait in FrmClkDiv cycles after reset, enable or bitslip before the lane word is compared; legal range 2..255.
REQ-005 Parameter LockCount, default 4: consecutive matching words required to declare lock; legal range 1..15.
REQ-006 Parameter UnlockCount, default 4: consecutive mismatching words while locked that cause loss of lock; legal range 1..15.
REQ-007 Parameter MaxSlips, default 2*AdcBits: bitslips allowed per lane before the lane fails; legal range 1..255.
REQ-008 FrmClkDiv  input  1: the single clock; all logic is rising-edge.
REQ-009 FrmRst  input  1: synchronous, active-high reset.
REQ-010 BitClkDone  input  1: bit-clock alignment complete; low holds all lanes in the reset condition.
REQ-011 ReAlign  input  1: single-cycle request to restart alignment on all lanes.
REQ-012 FrmWord  input  NumLanes*AdcBits: deserialiser outputs; lane i occupies [i*AdcBits +: AdcBits].
REQ-013 FrmBitslip  output  NumLanes: per-lane bitslip pulse to the deserialiser.
REQ-014 LaneLocked  output  NumLanes: per-lane lock status.
REQ-015 FrmAlignDone  output  1: all lanes locked.
REQ-016 FrmAlignErr  output  1: at least one lane failed.
REQ-017 SlipCount  output  NumLanes*8: per-lane count of bitslips issued since the last restart; lane i occupies [i*8 +: 8].

Function
REQ-018 Each lane shall run an independent FSM with states SETTLE, CHECK, SLIP, LOCKED and FAIL, plus a settle counter, match counter, miss counter and slip counter.
REQ-019 Restart condition = FrmRst, or BitClkDone low, or ReAlign; precedence FrmRst > BitClkDone > ReAlign. The resulting state and outputs are identical for all three.
REQ-020 On restart, every lane shall go to SETTLE with all counters cleared.
REQ-021 SETTLE: count for exactly SettleCycles cycles (counter 0..SettleCycles-1), then go to CHECK. The word is not compared during SETTLE.
REQ-022 CHECK: compare the lane word against FrmPattern[AdcBits-1:0] every cycle.
REQ-023 CHECK, on a match: increment the match counter; when the incremented value equals LockCount, go to LOCKED.
REQ-024 CHECK, on a mismatch: clear the match counter; if the slip counter equals MaxSlips, go to FAIL; otherwise go to SLIP.
REQ-025 SLIP lasts exactly one cycle:
- FrmBitslip[i] is high only in this state.
- The slip counter increments, saturating at 255.
- The next state is SETTLE with the settle counter cleared.
REQ-026 LOCKED, LaneLocked[i]=1:
- A match clears the miss counter.
- A mismatch increments the miss counter.
- When the miss counter reaches UnlockCount, go to SETTLE with the slip and match counters cleared; LaneLocked[i] drops in that SETTLE cycle.
REQ-027 FAIL: terminal state; LaneLocked[i]=0 and FrmBitslip[i]=0 until a restart condition.
REQ-028 Outputs are decoded from registered state, with zero additional delay:
- FrmBitslip[i] = (state==SLIP).
- LaneLocked[i] = (state==LOCKED).
- SlipCount = the slip counter.
REQ-029 FrmAlignDone and FrmAlignErr shall be registered, one cycle after the lane states:
- FrmAlignDone = AND of LaneLocked.
- FrmAlignErr = OR of (state==FAIL).
REQ-030 FrmBitslip shall never be high in two consecutive cycles on the same lane.
REQ-031 A lane in FAIL shall not affect the state machines of the other lanes.

Reset
REQ-032 While FrmRst=1, all of the following hold at the next clock edge:
- FrmBitslip=0, LaneLocked=0, FrmAlignDone=0, FrmAlignErr=0, SlipCount=0.
- All lanes are in SETTLE with counters at 0.
REQ-033 Reset asserted mid-operation, in any state including SLIP, shall take effect at the next edge; no partial bitslip pulse is produced afterwards.

Verification
REQ-034 Test configuration is AdcBits=14, NumLanes=2, SettleCycles=32, LockCount=4, MaxSlips=28. Both lanes hold 14'h3F80 from reset release:
- Required: LaneLocked=2'b11 at cycle 36 after release.
- Required: FrmAlignDone=1 at cycle 37.
- Required: SlipCount=0 and no FrmBitslip pulses.
REQ-035 A bench deserialiser model needs 3 slips on lane 0:
- Required: exactly 3 single-cycle FrmBitslip[0] pulses, each separated by 32 SETTLE cycles plus 1 CHECK cycle.
- Required: SlipCount[7:0]=3, then lane 0 locks.
REQ-036 Lane 1 word is held at 14'h0000 permanently:
- Required: 28 slips, then FAIL; FrmAlignErr=1 and FrmAlignDone=0.
- Required: lane 0 still locks.
- Required: a ReAlign pulse clears FrmAlignErr and SlipCount.
REQ-037 Both lanes are locked; lane 0 is then corrupted for 3 cycles, followed by a correct word:
- Required: lane stays locked.
- Corruption for 4 cycles instead: LaneLocked[0] drops after the 4th, FrmAlignDone drops one cycle later, and realignment restarts with SlipCount[7:0]=0.
REQ-038 BitClkDone is lowered mid-SETTLE, and separately FrmRst is asserted in the SLIP cycle:
- Required: all outputs are 0 at the next edge.
- Required: after release, no bitslip pulse appears before 33 cycles have elapsed.
